// File: rtl/mtx_pkg.sv
// Shared encodings for the multi-transmitter slot scheduler: FSM states, settings-bus
// offsets, CTRL bit positions and reset-time window lengths.
package mtx_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StPrmb  = 3'd2,
    StGuard = 3'd3,
    StTx    = 3'd4
  } sched_state_e;

  localparam logic [7:0] SrCtrl     = 8'd0;
  localparam logic [7:0] SrPrmbLen  = 8'd1;
  localparam logic [7:0] SrGuardLen = 8'd2;
  localparam logic [7:0] SrSlotMask = 8'd3;

  localparam int unsigned CtrlEnable  = 0;
  localparam int unsigned CtrlCont    = 1;
  localparam int unsigned CtrlClrMiss = 2;

  // 2046 preamble bits at 128x oversampling
  localparam int unsigned DefPrmbLen  = 261888;
  localparam int unsigned DefGuardLen = 32768;

endpackage

// File: rtl/mtx_sync_edge.sv
// Two-flop synchronizer for one asynchronous input bit, followed by a rising-edge detector.
module mtx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/mtx_slot_sched.sv
// Frame scheduler: on a front-panel sync edge, walks the enabled slots through
// preamble, guard and signal windows, gating the TX chain accordingly.
module mtx_slot_sched
  import mtx_pkg::*;
#(
  parameter logic [7:0]  SR_BASE        = 8'd0,
  parameter int unsigned NSLOT          = 4,
  parameter int unsigned LEN_WIDTH      = 20,
  parameter int unsigned DEF_PRMB_LEN   = DefPrmbLen,
  parameter int unsigned DEF_GUARD_LEN  = DefGuardLen,
  parameter int unsigned SYNC_BIT       = 0,
  parameter int unsigned GPIO_REG_WIDTH = 12,
  localparam int unsigned SW            = $clog2(NSLOT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
  input  logic                      gen_done,
  output logic                      gen_srst,
  output logic                      prmb_sel,
  output logic                      prmb_start,
  output logic                      tx_valid,
  output logic [SW-1:0]             slot_idx,
  output logic [2:0]                sched_state,
  output logic [15:0]               frame_cnt,
  output logic                      sync_miss
);

  sched_state_e         state_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] prmb_len_q, guard_len_q;
  logic [NSLOT-1:0]     mask_q;
  logic [SW-1:0]        slot_q;
  logic [15:0]          frame_q;
  logic                 enable_q, cont_q, miss_q, start_q;

  logic                 sync_rise;
  logic [NSLOT-1:0]     above_mask;
  logic [SW-1:0]        first_slot, next_slot;
  logic                 has_next;
  logic [LEN_WIDTH-1:0] wr_len;
  logic                 wr_ctrl, wr_prmb, wr_guard, wr_mask, clr_miss;
  logic                 unused_inputs;

  mtx_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (fp_gpio_in[SYNC_BIT]),
    .rise  (sync_rise)
  );

  function automatic logic [SW-1:0] lowest_set(input logic [NSLOT-1:0] m);
    lowest_set = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SW'(i);
    end
  endfunction

  always_comb begin
    above_mask = '0;
    for (int i = 0; i < NSLOT; i++) begin
      above_mask[i] = mask_q[i] && (i > int'(slot_q));
    end
  end

  assign first_slot = lowest_set(mask_q);
  assign next_slot  = lowest_set(above_mask);
  assign has_next   = |above_mask;

  assign wr_ctrl  = set_stb && (set_addr == SR_BASE + SrCtrl);
  assign wr_prmb  = set_stb && (set_addr == SR_BASE + SrPrmbLen);
  assign wr_guard = set_stb && (set_addr == SR_BASE + SrGuardLen);
  assign wr_mask  = set_stb && (set_addr == SR_BASE + SrSlotMask);
  assign clr_miss = wr_ctrl && set_data[CtrlClrMiss];
  // Zero-length windows would underflow the down-counter; clamp to one cycle.
  assign wr_len   = (set_data[LEN_WIDTH-1:0] == '0) ? LEN_WIDTH'(1) : set_data[LEN_WIDTH-1:0];

  assign unused_inputs = ^{set_data, fp_gpio_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      prmb_len_q  <= LEN_WIDTH'(DEF_PRMB_LEN);
      guard_len_q <= LEN_WIDTH'(DEF_GUARD_LEN);
      mask_q      <= '1;
      slot_q      <= '0;
      frame_q     <= '0;
      enable_q    <= 1'b0;
      cont_q      <= 1'b0;
      miss_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (wr_ctrl) begin
        enable_q <= set_data[CtrlEnable];
        cont_q   <= set_data[CtrlCont];
      end
      if (wr_prmb)  prmb_len_q  <= wr_len;
      if (wr_guard) guard_len_q <= wr_len;
      if (wr_mask)  mask_q      <= set_data[NSLOT-1:0];

      // Set is evaluated last so a coincident sync edge beats the clear.
      if (clr_miss) miss_q <= 1'b0;
      if (sync_rise && (state_q != StArm)) miss_q <= 1'b1;

      if (!enable_q) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StArm;
          StArm: begin
            if (sync_rise && (|mask_q)) begin
              slot_q  <= first_slot;
              state_q <= StPrmb;
              cnt_q   <= prmb_len_q - LEN_WIDTH'(1);
              start_q <= 1'b1;
            end
          end
          StPrmb: begin
            if (cnt_q == '0) begin
              state_q <= StGuard;
              cnt_q   <= guard_len_q - LEN_WIDTH'(1);
            end else begin
              cnt_q <= cnt_q - LEN_WIDTH'(1);
            end
          end
          StGuard: begin
            if (cnt_q == '0) state_q <= StTx;
            else             cnt_q   <= cnt_q - LEN_WIDTH'(1);
          end
          StTx: begin
            if (gen_done) begin
              if (has_next) begin
                slot_q  <= next_slot;
                state_q <= StPrmb;
                cnt_q   <= prmb_len_q - LEN_WIDTH'(1);
                start_q <= 1'b1;
              end else begin
                frame_q <= frame_q + 16'd1;
                state_q <= cont_q ? StArm : StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign gen_srst    = (state_q != StTx);
  assign prmb_sel    = (state_q == StPrmb);
  assign tx_valid    = (state_q == StPrmb) || (state_q == StTx);
  assign prmb_start  = start_q;
  assign slot_idx    = slot_q;
  assign sched_state = state_q;
  assign frame_cnt   = frame_q;
  assign sync_miss   = miss_q;

endmodule

// File: tb/tb_mtx_slot_sched.sv
// Directed self-checking bench for mtx_slot_sched: window timing, masking, sync handling,
// abort and asynchronous reset behaviour.
module tb_mtx_slot_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [11:0] fp_gpio_in = '0;
  logic        gen_done = 1'b0;
  logic        gen_srst, prmb_sel, prmb_start, tx_valid, sync_miss;
  logic [1:0]  slot_idx;
  logic [2:0]  sched_state;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [7:0] A_CTRL = 8'd0, A_PRMB = 8'd1, A_GUARD = 8'd2, A_MASK = 8'd3;
  localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_PRMB = 3'd2, S_GUARD = 3'd3, S_TX = 3'd4;

  mtx_slot_sched dut (
    .clk         (clk),
    .reset       (reset),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .fp_gpio_in  (fp_gpio_in),
    .gen_done    (gen_done),
    .gen_srst    (gen_srst),
    .prmb_sel    (prmb_sel),
    .prmb_start  (prmb_start),
    .tx_valid    (tx_valid),
    .slot_idx    (slot_idx),
    .sched_state (sched_state),
    .frame_cnt   (frame_cnt),
    .sync_miss   (sync_miss)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_stb = 1'b0;
    gen_done = 1'b0;
    fp_gpio_in = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic sr_write(input logic [7:0] addr, input logic [31:0] data);
    set_stb = 1'b1;
    set_addr = addr;
    set_data = data;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic sync_pulse();
    fp_gpio_in[0] = 1'b1;
    tick();
    fp_gpio_in[0] = 1'b0;
  endtask

  // Cycles spent in state st from the current cycle onward; returns in the next state.
  task automatic measure(input logic [2:0] st, output int n);
    n = 0;
    while (sched_state == st && n < 200) begin
      n++;
      tick();
    end
  endtask

  // Current cycle is TX cycle 1; gen_done seen at the end of TX cycle ncyc.
  task automatic run_tx(input int ncyc);
    for (int i = 0; i < ncyc - 1; i++) tick();
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
  endtask

  // Enable, wait one cycle for ARM, then sync; returns in the first PRMB cycle.
  task automatic start_frame(input logic [31:0] ctrl);
    sr_write(A_CTRL, ctrl);
    tick();
    check("arm_entry", sched_state, S_ARM);
    sync_pulse();
    tick();
    check("arm_hold_edge2", sched_state, S_ARM);
    tick();
  endtask

  initial begin
    int n;

    // Reset values
    do_reset();
    check("rst_state", sched_state, S_IDLE);
    check("rst_srst", gen_srst, 1'b1);
    check("rst_txv", tx_valid, 1'b0);
    check("rst_psel", prmb_sel, 1'b0);
    check("rst_pstart", prmb_start, 1'b0);
    check("rst_frame", frame_cnt, 16'd0);
    check("rst_miss", sync_miss, 1'b0);
    check("rst_slot", slot_idx, 2'd0);

    // 1: two-slot continuous frame
    sr_write(A_PRMB, 32'd8);
    sr_write(A_GUARD, 32'd4);
    sr_write(A_MASK, 32'b0101);
    start_frame(32'd3);
    check("t1_s0_state", sched_state, S_PRMB);
    check("t1_s0_slot", slot_idx, 2'd0);
    check("t1_s0_pstart", prmb_start, 1'b1);
    check("t1_s0_psel", prmb_sel, 1'b1);
    check("t1_s0_txv", tx_valid, 1'b1);
    tick();
    check("t1_pstart_pulse", prmb_start, 1'b0);
    measure(S_PRMB, n);
    check("t1_s0_prmb_len", n + 1, 8);
    check("t1_s0_guard_txv", tx_valid, 1'b0);
    check("t1_s0_guard_srst", gen_srst, 1'b1);
    measure(S_GUARD, n);
    check("t1_s0_guard_len", n, 4);
    check("t1_s0_tx_state", sched_state, S_TX);
    check("t1_s0_tx_srst", gen_srst, 1'b0);
    check("t1_s0_tx_txv", tx_valid, 1'b1);
    run_tx(10);
    check("t1_s2_state", sched_state, S_PRMB);
    check("t1_s2_slot", slot_idx, 2'd2);
    check("t1_s2_pstart", prmb_start, 1'b1);
    measure(S_PRMB, n);
    check("t1_s2_prmb_len", n, 8);
    measure(S_GUARD, n);
    check("t1_s2_guard_len", n, 4);
    run_tx(10);
    check("t1_end_state", sched_state, S_ARM);
    check("t1_frame", frame_cnt, 16'd1);
    check("t1_miss", sync_miss, 1'b0);

    // 2: empty slot mask keeps the scheduler armed
    do_reset();
    sr_write(A_MASK, 32'd0);
    start_frame(32'd1);
    tick();
    tick();
    check("t2_state", sched_state, S_ARM);
    check("t2_txv", tx_valid, 1'b0);
    check("t2_frame", frame_cnt, 16'd0);

    // 3: sync during TX flags a miss without disturbing timing; clear semantics
    do_reset();
    sr_write(A_PRMB, 32'd8);
    sr_write(A_GUARD, 32'd4);
    sr_write(A_MASK, 32'b0001);
    start_frame(32'd1);
    measure(S_PRMB, n);
    check("t3_prmb_len", n, 8);
    measure(S_GUARD, n);
    check("t3_guard_len", n, 4);
    sync_pulse();
    tick();
    tick();
    tick();
    check("t3_miss_set", sync_miss, 1'b1);
    check("t3_tx_held", sched_state, S_TX);
    run_tx(6);
    check("t3_end_state", sched_state, S_IDLE);
    check("t3_frame", frame_cnt, 16'd1);
    sr_write(A_CTRL, 32'd4);
    check("t3_miss_clr", sync_miss, 1'b0);
    sync_pulse();
    tick();
    sr_write(A_CTRL, 32'd4);
    check("t3_set_beats_clr", sync_miss, 1'b1);
    sr_write(A_CTRL, 32'd4);
    check("t3_miss_clr2", sync_miss, 1'b0);

    // 4: disabling mid-preamble aborts the slot
    do_reset();
    sr_write(A_PRMB, 32'd8);
    sr_write(A_GUARD, 32'd4);
    sr_write(A_MASK, 32'b0001);
    start_frame(32'd1);
    tick();
    tick();
    sr_write(A_CTRL, 32'd0);
    check("t4_still_prmb", sched_state, S_PRMB);
    tick();
    check("t4_idle", sched_state, S_IDLE);
    check("t4_srst", gen_srst, 1'b1);
    check("t4_txv", tx_valid, 1'b0);
    check("t4_psel", prmb_sel, 1'b0);

    // 5: asynchronous reset between clock edges during TX
    do_reset();
    sr_write(A_PRMB, 32'd2);
    sr_write(A_GUARD, 32'd2);
    sr_write(A_MASK, 32'b0001);
    start_frame(32'd1);
    measure(S_PRMB, n);
    measure(S_GUARD, n);
    tick();
    check("t5_in_tx", sched_state, S_TX);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_srst", gen_srst, 1'b1);
    check("t5_async_txv", tx_valid, 1'b0);
    check("t5_async_state", sched_state, S_IDLE);
    #2;
    reset = 1'b0;
    tick();

    // 6: zero-length preamble and length write during a running window
    do_reset();
    sr_write(A_PRMB, 32'd0);
    sr_write(A_GUARD, 32'd4);
    sr_write(A_MASK, 32'b0111);
    start_frame(32'd1);
    measure(S_PRMB, n);
    check("t6_prmb_zero", n, 1);
    measure(S_GUARD, n);
    check("t6_guard0", n, 4);
    sr_write(A_PRMB, 32'd8);
    run_tx(2);
    check("t6_s1_slot", slot_idx, 2'd1);
    sr_write(A_PRMB, 32'd3);
    measure(S_PRMB, n);
    check("t6_prmb_keep8", n + 1, 8);
    measure(S_GUARD, n);
    run_tx(3);
    check("t6_s2_slot", slot_idx, 2'd2);
    measure(S_PRMB, n);
    check("t6_prmb_new3", n, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
